zint_start_gen: RTL and testbench

- Generates the one-cycle `int_start` strobe that the frame-INT stage consumes to begin its INT pulse.
- Tracks raster position with horizontal and vertical counters, driven by the video sync strobes.
- Fires when the position matches the programmed INT position: once per frame, or once per line in line-INT mode.
- Sits between the video sync generator / port decoder and the frame-INT stage.

---
 rtl/zint_start_gen.sv | 181 ++++++++++++++++++
 tb/tb_zint_start_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/zint_start_gen.sv
// zint_start_gen: raster-position INT start strobe generator.
// Horizontal/vertical counters follow the video sync strobes. A one-fclk
// int_start strobe is raised one cycle after the counters match the shadow
// INT position, at most once per frame.
// Optional build macro: ZINT_LINEINT_EN. When it is defined, shadow mode=1
// selects line-INT: the vertical compare is dropped and the strobe re-arms on
// every line_start. When it is undefined, the mode bit is still written and
// stored but has no effect.
module zint_start_gen #(
    parameter int          HCNT_W = 9,
    parameter int          VCNT_W = 9,
    parameter logic [8:0]  DEF_V  = 9'd0,
    parameter logic [7:0]  DEF_H  = 8'd0
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              cend,
    input  logic              pos_wr,
    input  logic [1:0]        pos_addr,
    input  logic [7:0]        pos_data,
    output logic              int_start,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                fire_s;
    logic                int_start_r;

    logic [8:0]          v_r;
    logic [7:0]          h_r;
    logic                mode_r;
    logic [8:0]          v_sh_r;
    logic [7:0]          h_sh_r;
    logic                mode_sh_r;

    logic [HCNT_W-1:0]   hcnt_r;
    logic [VCNT_W-1:0]   vcnt_r;

    logic                line_mode_s;
    logic                v_match_s;
    logic                h_match_s;
    logic                match_s;

`ifdef ZINT_LINEINT_EN
    assign line_mode_s = mode_sh_r;
`else
    // Mode is kept for readback compatibility but frame mode is forced.
    assign line_mode_s = mode_sh_r & 1'b0;
`endif

    // Compare the registered raster position against the shadow INT position.
    assign v_match_s = (vcnt_r == VCNT_W'(v_sh_r));
    assign h_match_s = (hcnt_r == HCNT_W'({h_sh_r, 1'b0}));
    assign match_s   = h_match_s && (v_match_s || line_mode_s);

    // Working position registers, written by the port decoder.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            v_r    <= DEF_V;
            h_r    <= DEF_H;
            mode_r <= 1'b0;
        end else if (pos_wr) begin
            case (pos_addr)
                2'd0: v_r[7:0] <= pos_data;
                2'd1: begin
                    mode_r <= pos_data[7];
                    v_r[8] <= pos_data[0];
                end
                2'd2: h_r <= pos_data;
                default: ;
            endcase
        end else begin
            v_r <= v_r;
        end
    end

    // Shadow copy taken at frame start so mid-frame writes apply next frame.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            v_sh_r    <= DEF_V;
            h_sh_r    <= DEF_H;
            mode_sh_r <= 1'b0;
        end else if (frame_start) begin
            v_sh_r    <= v_r;
            h_sh_r    <= h_r;
            mode_sh_r <= mode_r;
        end else begin
            v_sh_r <= v_sh_r;
        end
    end

    // Raster counters: frame_start beats line_start beats cend; both saturate.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            hcnt_r <= {HCNT_W{1'b0}};
            vcnt_r <= {VCNT_W{1'b0}};
        end else if (frame_start) begin
            hcnt_r <= {HCNT_W{1'b0}};
            vcnt_r <= {VCNT_W{1'b0}};
        end else if (line_start) begin
            hcnt_r <= {HCNT_W{1'b0}};
            if (vcnt_r != {VCNT_W{1'b1}}) begin
                vcnt_r <= vcnt_r + {{(VCNT_W-1){1'b0}}, 1'b1};
            end else begin
                vcnt_r <= vcnt_r;
            end
        end else if (cend) begin
            if (hcnt_r != {HCNT_W{1'b1}}) begin
                hcnt_r <= hcnt_r + {{(HCNT_W-1){1'b0}}, 1'b1};
            end else begin
                hcnt_r <= hcnt_r;
            end
        end else begin
            hcnt_r <= hcnt_r;
        end
    end

    // Next-state and fire decision; frame_start always re-arms and masks a match.
    always_comb begin
        state_nxt_s = state_r;
        fire_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (frame_start) begin
                    state_nxt_s = ST_ARMED;
                end else if (match_s) begin
                    state_nxt_s = ST_FIRED;
                    fire_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_FIRED: begin
                if (frame_start) begin
                    state_nxt_s = ST_ARMED;
                end else if (line_start && line_mode_s) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_FIRED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                fire_s      = 1'b0;
            end
        endcase
    end

    // State register and registered one-cycle strobe.
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            int_start_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            int_start_r <= fire_s;
        end
    end

    assign int_start = int_start_r;
    assign hcnt      = hcnt_r;
    assign vcnt      = vcnt_r;

endmodule

// File: tb/tb_zint_start_gen.sv
// Self-checking bench for zint_start_gen: a constant vector table for the
// start-up / priority corner cases, frame-level pulse counts, and per-cycle
// comparison against a position/flag reference model under random stimulus.
module tb_zint_start_gen;

`ifdef ZINT_LINEINT_EN
    localparam bit LINEINT = 1'b1;
`else
    localparam bit LINEINT = 1'b0;
`endif

    logic       fclk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       line_start;
    logic       cend;
    logic       pos_wr;
    logic [1:0] pos_addr;
    logic [7:0] pos_data;
    logic       int_start;
    logic [8:0] hcnt;
    logic [8:0] vcnt;

    zint_start_gen dut (
        .fclk        (fclk),
        .rst         (rst),
        .frame_start (frame_start),
        .line_start  (line_start),
        .cend        (cend),
        .pos_wr      (pos_wr),
        .pos_addr    (pos_addr),
        .pos_data    (pos_data),
        .int_start   (int_start),
        .hcnt        (hcnt),
        .vcnt        (vcnt)
    );

    always #5 fclk = ~fclk;

    int errors = 0;
    int checks = 0;

    // Reference model: programmed registers, raster position, and whether the
    // INT has already been delivered in the current frame (or line).
    int m_vw, m_hw, m_vs, m_hs;
    bit m_modew, m_modes;
    int m_hc, m_vc;
    bit m_seen, m_done, m_pulse;
    int pulse_cnt, pulse_v;

    typedef struct {
        bit fs;
        bit ls;
        bit ce;
        bit e_int;
        int e_hc;
        int e_vc;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_vw = 0; m_hw = 0; m_vs = 0; m_hs = 0;
        m_modew = 1'b0; m_modes = 1'b0;
        m_hc = 0; m_vc = 0;
        m_seen = 1'b0; m_done = 1'b0; m_pulse = 1'b0;
    endtask

    // One fclk cycle: drive inputs, advance model, compare after the edge.
    task automatic step(input bit fs, input bit ls, input bit ce,
                        input bit wr, input int addr, input int data);
        bit lm;
        bit hit;
        frame_start = fs;
        line_start  = ls;
        cend        = ce;
        pos_wr      = wr;
        pos_addr    = addr[1:0];
        pos_data    = data[7:0];

        lm  = LINEINT && m_modes;
        hit = m_seen && !m_done && (m_hc == 2 * m_hs) && (lm || (m_vc == m_vs));
        m_pulse = hit && !fs;
        if (fs) begin
            m_seen = 1'b1;
            m_done = 1'b0;
        end else if (hit) begin
            m_done = 1'b1;
        end else if (ls && lm) begin
            m_done = 1'b0;
        end

        if (fs) begin
            m_hs = m_hw; m_vs = m_vw; m_modes = m_modew;
        end
        if (fs) begin
            m_hc = 0; m_vc = 0;
        end else if (ls) begin
            m_hc = 0;
            m_vc = (m_vc < 511) ? m_vc + 1 : 511;
        end else if (ce) begin
            m_hc = (m_hc < 511) ? m_hc + 1 : 511;
        end
        if (wr) begin
            case (addr)
                0: m_vw = (m_vw & 256) | (data & 255);
                1: begin
                    m_modew = ((data >> 7) & 1) == 1;
                    m_vw = (m_vw & 255) | ((data & 1) << 8);
                end
                2: m_hw = data & 255;
                default: ;
            endcase
        end

        @(posedge fclk);
        #1;
        frame_start = 1'b0; line_start = 1'b0; cend = 1'b0; pos_wr = 1'b0;
        check("model_int_start", int'(int_start), int'(m_pulse));
        check("model_hcnt", int'(hcnt), m_hc);
        check("model_vcnt", int'(vcnt), m_vc);
        if (int_start) begin
            pulse_cnt++;
            pulse_v = int'(vcnt);
        end
    endtask

    task automatic wr_reg(input int addr, input int data);
        step(1'b0, 1'b0, 1'b0, 1'b1, addr, data);
    endtask

    // One frame: nl lines of nc cend strobes with random idle gaps; optional
    // write at the first pixel of line wr_line.
    task automatic run_frame(input int nl, input int nc, input int wr_line,
                             input int wa, input int wd);
        pulse_cnt = 0;
        pulse_v   = -1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int l = 0; l < nl; l++) begin
            if (l > 0) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
            for (int c = 0; c < nc; c++) begin
                bit w;
                w = (l == wr_line) && (c == 0);
                step(1'b0, 1'b0, 1'b1, w, wa, wd);
                if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0; line_start = 1'b0; cend = 1'b0;
        pos_wr = 1'b0; pos_addr = 2'd0; pos_data = 8'd0;
        model_reset();
        repeat (3) @(posedge fclk);
        #3;
        check("reset_int_start", int'(int_start), 0);
        check("reset_hcnt", int'(hcnt), 0);
        check("reset_vcnt", int'(vcnt), 0);
        rst = 1'b0;
        @(posedge fclk);
        #1;

        // Start-up latency and same-cycle strobe priority, defaults V=0 H=0.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2, 0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].fs, tbl[i].ls, tbl[i].ce, 1'b0, 0, 0);
            check($sformatf("tbl%0d_int", i), int'(int_start), int'(tbl[i].e_int));
            check($sformatf("tbl%0d_hcnt", i), int'(hcnt), tbl[i].e_hc);
            check($sformatf("tbl%0d_vcnt", i), int'(vcnt), tbl[i].e_vc);
        end

        // Reset in the middle of the pulse drops int_start without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_int_start", int'(int_start), 0);
        @(negedge fclk);
        rst = 1'b0;
        model_reset();
        @(posedge fclk);
        #1;

        // Default position: one pulse per frame, on line 0.
        for (int f = 0; f < 3; f++) begin
            run_frame(6, 4, -1, 0, 0);
            check($sformatf("def_frame%0d_pulses", f), pulse_cnt, 1);
            check($sformatf("def_frame%0d_line", f), pulse_v, 0);
        end

        // V=0x120, H=0x10: line 288, hcnt 32, once per frame.
        wr_reg(0, 8'h20);
        wr_reg(1, 8'h01);
        wr_reg(2, 8'h10);
        for (int f = 0; f < 2; f++) begin
            run_frame(290, 34, -1, 0, 0);
            check($sformatf("v288_frame%0d_pulses", f), pulse_cnt, 1);
            check($sformatf("v288_frame%0d_line", f), pulse_v, 288);
        end

        // Mid-frame V change applies from the next frame only.
        wr_reg(0, 8'h03);
        wr_reg(1, 8'h00);
        wr_reg(2, 8'h00);
        run_frame(8, 3, -1, 0, 0);
        run_frame(8, 3, 1, 0, 8'h05);
        check("midwr_cur_pulses", pulse_cnt, 1);
        check("midwr_cur_line", pulse_v, 3);
        run_frame(8, 3, -1, 0, 0);
        check("midwr_next_pulses", pulse_cnt, 1);
        check("midwr_next_line", pulse_v, 5);

        // Unreachable V: silent for two frames, then resumes.
        wr_reg(0, 8'hFF);
        wr_reg(1, 8'h01);
        for (int f = 0; f < 2; f++) begin
            run_frame(320, 2, -1, 0, 0);
            check($sformatf("unreach_frame%0d_pulses", f), pulse_cnt, 0);
        end
        wr_reg(0, 8'h10);
        wr_reg(1, 8'h00);
        run_frame(320, 2, -1, 0, 0);
        check("resume_pulses", pulse_cnt, 1);
        check("resume_line", pulse_v, 16);

        // Mode=1, H=8: per-line INT when the feature is built in.
        wr_reg(0, 8'h00);
        wr_reg(1, 8'h80);
        wr_reg(2, 8'h08);
        for (int f = 0; f < 2; f++) begin
            run_frame(312, 20, -1, 0, 0);
            check($sformatf("linemode_frame%0d_pulses", f), pulse_cnt, LINEINT ? 312 : 1);
        end
        wr_reg(1, 8'h00);
        run_frame(1, 0, -1, 0, 0);
        run_frame(6, 20, -1, 0, 0);
        check("mode0_pulses", pulse_cnt, 1);

        // Counter saturation at all-ones.
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 515; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        check("hcnt_saturate", int'(hcnt), 511);
        for (int i = 0; i < 515; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        check("vcnt_saturate", int'(vcnt), 511);

        // Random strobes and writes against the model.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
